serial_rx: RTL and testbench

Single-bit serial frame receiver. It is the receive end of the registered, inverted one-bit `dataout` stream that the `TOP` → `SUB` → `SUBSUB` chain drives. The block takes one line bit per `clk` and undoes the line inversion. It then frames start/data/parity/stop bits and presents each good word on a ready/valid output with a one-entry holding register. Error and overrun events are reported as single-cycle pulses.

---
 rtl/serial_rx_pkg.sv | 8 +
 rtl/serial_rx_in.sv | 18 +
 rtl/serial_rx.sv | 102 ++++++++++
 tb/tb_serial_rx.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/serial_rx_pkg.sv
// serial_rx_pkg: shared types and constants for the serial frame receiver
package serial_rx_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;
  localparam logic RX_IDLE_LVL = 1'b1;
  function automatic int frame_len(input int data_w, input int parity_en);
    return data_w + 2 + parity_en;
  endfunction
endpackage

// File: rtl/serial_rx_in.sv
// serial_rx_in: registered line input with optional inversion, resets to logical idle
module serial_rx_in
  import serial_rx_pkg::*;
#(
  parameter int INVERT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic datain_i,
  output logic rx_o
);
  logic rx_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_q <= RX_IDLE_LVL;
    else        rx_q <= datain_i ^ 1'(INVERT);
  end
  assign rx_o = rx_q;
endmodule

// File: rtl/serial_rx.sv
// serial_rx: start/data/parity/stop framer with one-entry ready/valid holding register
module serial_rx
  import serial_rx_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int INVERT    = 1,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              datain,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);
  localparam logic [4:0] LAST = 5'(DATA_W - 1);
  rx_state_t         state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d, data_q, data_d;
  logic              par_q, par_d, valid_q, valid_d;
  logic              perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic              rx_q, par_bad;
  serial_rx_in #(.INVERT(INVERT)) u_in (
    .clk      (clk),
    .rst_n    (rst_n),
    .datain_i (datain),
    .rx_o     (rx_q)
  );
  assign par_bad = (PARITY_EN != 0) && ((^shift_q) != par_q);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    data_d  = data_q;
    valid_d = valid_q && !out_ready;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = rx_q ? IDLE : DATA;
        cnt_d   = '0;
      end
      DATA: begin
        // new bits enter at the MSB so the first bit lands at bit 0 after DATA_W shifts
        shift_d = (shift_q >> 1) | (DATA_W'(rx_q) << (DATA_W - 1));
        cnt_d   = cnt_q + 5'd1;
        state_d = (cnt_q != LAST) ? DATA : (PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY: begin
        par_d   = rx_q;
        state_d = STOP;
      end
      STOP: begin
        state_d = IDLE;
        ferr_d  = !rx_q;
        perr_d  = rx_q && par_bad;
        if (rx_q && !par_bad) begin
          if (!valid_q || out_ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else ovr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end
  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: directed scenario tests for serial_rx, default and narrow no-parity builds
module tb_serial_rx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0;
  logic       rdy = 1'b0;
  logic [7:0] data;
  logic       vld, perr, ferr, ovr, bsy;
  logic       din2 = 1'b1;
  logic [4:0] data2;
  logic       vld2, perr2, ferr2, ovr2, bsy2;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  serial_rx dut (
    .clk(clk), .rst_n(rst_n), .datain(din), .out_data(data), .out_valid(vld),
    .out_ready(rdy), .parity_err(perr), .frame_err(ferr), .overrun(ovr), .busy(bsy)
  );

  serial_rx #(.DATA_W(5), .INVERT(0), .PARITY_EN(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .datain(din2), .out_data(data2), .out_valid(vld2),
    .out_ready(1'b0), .parity_err(perr2), .frame_err(ferr2), .overrun(ovr2), .busy(bsy2)
  );

  // drive one logical bit (raw line is inverted) and step past the sampling edge
  task automatic tick(input logic b);
    din = ~b;
    @(posedge clk);
    #1;
  endtask

  task automatic tick2(input logic b);
    din2 = b;
    @(posedge clk);
    #1;
  endtask

  // send bits lo..hi of {stop, parity, data, start}
  task automatic send(input logic [7:0] d, input logic p, input logic s, input int lo, input int hi);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    for (int i = lo; i <= hi; i++) tick(f[i]);
  endtask

  task automatic drain();
    rdy = 1'b1;
    tick(1'b1);
    rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_cmp++; if ({data, vld, perr, ferr, ovr, bsy} !== 13'd0) begin n_bad++; $display("FAIL reset_outputs got %h want 0", {data, vld, perr, ferr, ovr, bsy}); end
    n_cmp++; if ({data2, vld2, perr2, ferr2, ovr2, bsy2} !== 10'd0) begin n_bad++; $display("FAIL reset_outputs2 got %h want 0", {data2, vld2, perr2, ferr2, ovr2, bsy2}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1'b1);
    tick(1'b1);
    n_cmp++; if (bsy !== 1'b0) begin n_bad++; $display("FAIL idle_busy got %b want 0", bsy); end
  endtask

  task automatic test_good();
    send(8'hA5, 1'b0, 1'b1, 0, 2);
    n_cmp++; if (bsy !== 1'b1) begin n_bad++; $display("FAIL good_busy_mid got %b want 1", bsy); end
    send(8'hA5, 1'b0, 1'b1, 3, 10);
    n_cmp++; if (vld !== 1'b0) begin n_bad++; $display("FAIL good_valid_early got %b want 0", vld); end
    tick(1'b1);
    n_cmp++; if (vld !== 1'b1) begin n_bad++; $display("FAIL good_valid got %b want 1", vld); end
    n_cmp++; if (data !== 8'hA5) begin n_bad++; $display("FAIL good_data got %h want a5", data); end
    n_cmp++; if ({perr, ferr, ovr} !== 3'b000) begin n_bad++; $display("FAIL good_errs got %b want 000", {perr, ferr, ovr}); end
    n_cmp++; if (bsy !== 1'b0) begin n_bad++; $display("FAIL good_busy_end got %b want 0", bsy); end
    tick(1'b1);
    n_cmp++; if ({vld, data} !== {1'b1, 8'hA5}) begin n_bad++; $display("FAIL good_hold got %h want 1a5", {vld, data}); end
    drain();
    n_cmp++; if (vld !== 1'b0) begin n_bad++; $display("FAIL good_drain got %b want 0", vld); end
  endtask

  task automatic test_parity();
    send(8'hA5, 1'b1, 1'b1, 0, 10);
    tick(1'b1);
    n_cmp++; if (perr !== 1'b1) begin n_bad++; $display("FAIL par_pulse got %b want 1", perr); end
    n_cmp++; if ({vld, ferr, ovr} !== 3'b000) begin n_bad++; $display("FAIL par_others got %b want 000", {vld, ferr, ovr}); end
    tick(1'b1);
    n_cmp++; if (perr !== 1'b0) begin n_bad++; $display("FAIL par_width got %b want 0", perr); end
  endtask

  task automatic test_frame();
    send(8'h3C, 1'b0, 1'b0, 0, 10);
    send(8'h5A, 1'b0, 1'b1, 0, 0);
    n_cmp++; if ({ferr, perr, vld} !== 3'b100) begin n_bad++; $display("FAIL frm_pulse got %b want 100", {ferr, perr, vld}); end
    send(8'h5A, 1'b0, 1'b1, 1, 10);
    n_cmp++; if (ferr !== 1'b0) begin n_bad++; $display("FAIL frm_width got %b want 0", ferr); end
    tick(1'b1);
    n_cmp++; if ({vld, data} !== {1'b1, 8'h5A}) begin n_bad++; $display("FAIL frm_next got %h want 15a", {vld, data}); end
    n_cmp++; if ({perr, ferr, ovr} !== 3'b000) begin n_bad++; $display("FAIL frm_next_errs got %b want 000", {perr, ferr, ovr}); end
    drain();
  endtask

  task automatic test_overrun();
    send(8'h11, 1'b0, 1'b1, 0, 10);
    send(8'h22, 1'b0, 1'b1, 0, 10);
    n_cmp++; if ({vld, data} !== {1'b1, 8'h11}) begin n_bad++; $display("FAIL ovr_first got %h want 111", {vld, data}); end
    tick(1'b1);
    n_cmp++; if (ovr !== 1'b1) begin n_bad++; $display("FAIL ovr_pulse got %b want 1", ovr); end
    n_cmp++; if ({vld, data} !== {1'b1, 8'h11}) begin n_bad++; $display("FAIL ovr_keep got %h want 111", {vld, data}); end
    tick(1'b1);
    n_cmp++; if (ovr !== 1'b0) begin n_bad++; $display("FAIL ovr_width got %b want 0", ovr); end
    drain();
    send(8'h11, 1'b0, 1'b1, 0, 10);
    send(8'h22, 1'b0, 1'b1, 0, 10);
    rdy = 1'b1;
    tick(1'b1);
    rdy = 1'b0;
    n_cmp++; if ({vld, data} !== {1'b1, 8'h22}) begin n_bad++; $display("FAIL ovr_drain_load got %h want 122", {vld, data}); end
    n_cmp++; if (ovr !== 1'b0) begin n_bad++; $display("FAIL ovr_drain_noovr got %b want 0", ovr); end
  endtask

  task automatic test_reset_mid();
    send(8'hFF, 1'b0, 1'b1, 0, 4);
    n_cmp++; if (bsy !== 1'b1) begin n_bad++; $display("FAIL rstm_busy_pre got %b want 1", bsy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({data, vld, perr, ferr, ovr, bsy} !== 13'd0) begin n_bad++; $display("FAIL rstm_outputs got %h want 0", {data, vld, perr, ferr, ovr, bsy}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1'b1);
    send(8'hFF, 1'b0, 1'b1, 0, 10);
    tick(1'b1);
    n_cmp++; if ({vld, data} !== {1'b1, 8'hFF}) begin n_bad++; $display("FAIL rstm_after got %h want 1ff", {vld, data}); end
    drain();
  endtask

  task automatic test_sweep();
    logic [6:0] raw;
    raw = 7'b1011010;
    for (int i = 0; i < 7; i++) tick2(raw[i]);
    tick2(1'b1);
    n_cmp++; if ({vld2, data2} !== {1'b1, 5'b01101}) begin n_bad++; $display("FAIL sweep_data got %b want 101101", {vld2, data2}); end
    n_cmp++; if ({perr2, ferr2, ovr2, bsy2} !== 4'b0000) begin n_bad++; $display("FAIL sweep_flags got %b want 0000", {perr2, ferr2, ovr2, bsy2}); end
  endtask

  initial begin
    test_reset();
    test_good();
    test_parity();
    test_frame();
    test_overrun();
    test_reset_mid();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
